// File: rtl/gpio_beacon_pkg.sv
// Shared constants for the GPIO pin beacon: the header pin map, message characters and sequencer states.
package gpio_beacon_pkg;

  localparam int MAX_PINS = 32;

  // Index i is the header pin number driven by gpio_out[i].
  localparam int PIN_NUMS [MAX_PINS] = '{
    23, 25, 26, 27, 32, 35, 31, 37, 34, 43, 36, 42, 38, 28, 20, 10,
    12, 21, 13, 19, 18, 11,  9,  6, 44,  4,  3, 48, 45, 47, 46,  2
  };

  localparam int MSG_LEN = 9;

  localparam logic [7:0] ASCII_G    = 8'h47;
  localparam logic [7:0] ASCII_P    = 8'h50;
  localparam logic [7:0] ASCII_I    = 8'h49;
  localparam logic [7:0] ASCII_O    = 8'h4F;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] IDLE_CHAR  = 8'hFF;

  typedef enum logic [1:0] {GAP, START, DATA, STOP} beacon_state_e;

  function automatic logic [7:0] tens_char(input int pin);
    return ASCII_ZERO + 8'(pin / 10);
  endfunction

  function automatic logic [7:0] ones_char(input int pin);
    return ASCII_ZERO + 8'(pin % 10);
  endfunction

  function automatic logic [7:0] msg_char(input logic [3:0] idx, input logic [7:0] tens,
                                          input logic [7:0] ones);
    logic [7:0] c;
    case (idx)
      4'd0:    c = ASCII_G;
      4'd1:    c = ASCII_P;
      4'd2:    c = ASCII_I;
      4'd3:    c = ASCII_O;
      4'd4:    c = tens;
      4'd5:    c = ones;
      4'd6:    c = ASCII_CR;
      4'd7:    c = ASCII_LF;
      default: c = IDLE_CHAR;
    endcase
    return c;
  endfunction

  // The trailing idle character keeps its start bit high so the whole char-time is idle line.
  function automatic logic line_bit(input beacon_state_e st, input logic [3:0] idx,
                                    input logic [2:0] bit_idx, input logic [7:0] tens,
                                    input logic [7:0] ones);
    logic [7:0] c;
    logic       v;
    c = msg_char(idx, tens, ones);
    case (st)
      START:   v = (idx == 4'(MSG_LEN - 1));
      DATA:    v = c[bit_idx];
      default: v = 1'b1;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/gpio_pin_beacon_baud_tick.sv
// Free-running baud timer: one-cycle tick every CLOCK_HZ/BAUD clocks.
module baud_tick #(
  parameter int CLOCK_HZ = 12_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = CLOCK_HZ / BAUD;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("baud_tick: CLOCK_HZ/BAUD must be at least 2");
  end

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RELOAD;
    end else if (count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - 1'b1;
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/gpio_pin_beacon.sv
// Drives every GPIO pin with a repeating 8N1 "GPIOnn\r\n" message naming that pin.
module gpio_pin_beacon
  import gpio_beacon_pkg::*;
#(
  parameter int CLOCK_HZ = 12_000_000,
  parameter int BAUD     = 115_200,
  parameter int GAP_BITS = 16,
  parameter int NUM_PINS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic                msg_done,
  output logic                busy
);

  localparam int GW = $clog2(GAP_BITS + 1);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP_BITS);
  localparam logic [3:0]    LAST_CHAR  = 4'(MSG_LEN - 1);

  if (GAP_BITS < 1) begin : g_gap_check
    $error("gpio_pin_beacon: GAP_BITS must be at least 1");
  end
  if (NUM_PINS < 1 || NUM_PINS > MAX_PINS) begin : g_pins_check
    $error("gpio_pin_beacon: NUM_PINS out of range");
  end

  logic                tick;
  beacon_state_e       state, state_nx;
  logic [3:0]          char_idx, char_idx_nx;
  logic [2:0]          bit_idx, bit_idx_nx;
  logic [GW-1:0]       gap_cnt, gap_cnt_nx;
  logic                busy_nx, done_nx;
  logic [NUM_PINS-1:0] line_nx;

  baud_tick #(.CLOCK_HZ(CLOCK_HZ), .BAUD(BAUD)) u_baud (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // While disabled the gap count is held at full, so a restart always waits a complete gap.
  always_comb begin
    state_nx    = state;
    char_idx_nx = char_idx;
    bit_idx_nx  = bit_idx;
    gap_cnt_nx  = gap_cnt;
    busy_nx     = busy;
    done_nx     = 1'b0;
    if (tick) begin
      case (state)
        GAP: begin
          if (!enable) begin
            gap_cnt_nx = GAP_RELOAD;
          end else if (gap_cnt <= GW'(1)) begin
            gap_cnt_nx  = '0;
            state_nx    = START;
            char_idx_nx = '0;
            busy_nx     = 1'b1;
          end else begin
            gap_cnt_nx = gap_cnt - 1'b1;
          end
        end
        START: begin
          state_nx   = DATA;
          bit_idx_nx = '0;
        end
        DATA: begin
          if (bit_idx == 3'd7) begin
            state_nx = STOP;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (char_idx == LAST_CHAR) begin
            done_nx    = 1'b1;
            busy_nx    = 1'b0;
            gap_cnt_nx = GAP_RELOAD;
            state_nx   = GAP;
          end else if (enable) begin
            char_idx_nx = char_idx + 4'd1;
            state_nx    = START;
          end else begin
            busy_nx    = 1'b0;
            gap_cnt_nx = GAP_RELOAD;
            state_nx   = GAP;
          end
        end
        default: state_nx = GAP;
      endcase
    end
  end

  // Line levels come from the next state so every pin flips on the same edge as the state.
  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    localparam logic [7:0] PIN_TENS = tens_char(PIN_NUMS[i]);
    localparam logic [7:0] PIN_ONES = ones_char(PIN_NUMS[i]);
    assign line_nx[i] = line_bit(state_nx, char_idx_nx, bit_idx_nx, PIN_TENS, PIN_ONES);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= GAP;
      char_idx <= '0;
      bit_idx  <= '0;
      gap_cnt  <= GAP_RELOAD;
      busy     <= 1'b0;
      msg_done <= 1'b0;
      gpio_out <= '1;
    end else begin
      state    <= state_nx;
      char_idx <= char_idx_nx;
      bit_idx  <= bit_idx_nx;
      gap_cnt  <= gap_cnt_nx;
      busy     <= busy_nx;
      msg_done <= done_nx;
      gpio_out <= line_nx;
    end
  end

endmodule

// File: tb/tb_gpio_pin_beacon.sv
// Directed bench: a DIV=8 instance for waveform/timing checks plus a default-parameter instance for UART decode.
module tb_gpio_pin_beacon;

  logic        clk = 1'b0;
  logic        reset_s, enable_s, reset_d, enable_d;
  logic [31:0] gpio_s, gpio_d;
  logic        msg_done_s, busy_s, msg_done_d, busy_d;

  int assertions = 0;
  int failures   = 0;
  int run_bad, run_shared, run_diff, run_done;

  always #5 clk = ~clk;

  gpio_pin_beacon #(.CLOCK_HZ(8), .BAUD(1), .GAP_BITS(2), .NUM_PINS(32)) dut_small (
    .clk     (clk),
    .reset   (reset_s),
    .enable  (enable_s),
    .gpio_out(gpio_s),
    .msg_done(msg_done_s),
    .busy    (busy_s)
  );

  gpio_pin_beacon dut_default (
    .clk     (clk),
    .reset   (reset_d),
    .enable  (enable_d),
    .gpio_out(gpio_d),
    .msg_done(msg_done_d),
    .busy    (busy_d)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic en_v);
    reset_s  = rst_v;
    enable_s = en_v;
  endtask

  function automatic logic [7:0] exp_char(input int c, input logic [7:0] t, input logic [7:0] o);
    case (c)
      0: return 8'h47;
      1: return 8'h50;
      2: return 8'h49;
      3: return 8'h4F;
      4: return t;
      5: return o;
      6: return 8'h0D;
      7: return 8'h0A;
      default: return 8'hFF;
    endcase
  endfunction

  // Sample k counts clocks from the first start bit; each char-time is 80 clocks of 8-clock bits.
  function automatic logic exp_line(input int k, input logic [7:0] t, input logic [7:0] o);
    int c, b;
    logic [7:0] ch;
    c  = k / 80;
    b  = (k % 80) / 8;
    ch = exp_char(c, t, o);
    if (b == 0) return (c == 8);
    if (b == 9) return 1'b1;
    return ch[b-1];
  endfunction

  task automatic wait_start(input int p, output int n);
    n = 0;
    while (gpio_s[p] !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic sample_run(input int p, input logic [7:0] t, input logic [7:0] o,
                            input int k_from, input int k_to);
    for (int k = k_from; k < k_to; k++) begin
      int c, b;
      c = k / 80;
      b = (k % 80) / 8;
      if (gpio_s[p] !== exp_line(k, t, o)) run_bad++;
      if ((c <= 3 || c == 6 || c == 7) && gpio_s !== '0 && gpio_s !== '1) run_shared++;
      if (c == 5 && ((gpio_s[0] ^ gpio_s[1]) !== (b == 2 || b == 3))) run_diff++;
      if (msg_done_s !== 1'b0) run_done++;
      @(negedge clk);
    end
  endtask

  task automatic frame_check(input int p, input logic [7:0] t, input logic [7:0] o);
    run_bad = 0; run_shared = 0; run_diff = 0; run_done = 0;
    checkOutput($sformatf("busy_at_start_p%0d", p), busy_s, 1'b1);
    sample_run(p, t, o, 0, 720);
    checkOutput($sformatf("waveform_p%0d", p), run_bad, 0);
    checkOutput($sformatf("shared_chars_p%0d", p), run_shared, 0);
    checkOutput($sformatf("ones_diff_p%0d", p), run_diff, 0);
    checkOutput($sformatf("early_done_p%0d", p), run_done, 0);
    checkOutput($sformatf("msg_done_p%0d", p), msg_done_s, 1'b1);
    checkOutput($sformatf("busy_after_p%0d", p), busy_s, 1'b0);
  endtask

  task automatic decode_d(input int p, input bit measure, output logic [7:0] ch);
    int n, run;
    n = 0;
    while (gpio_d[p] !== 1'b0 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    if (measure) begin
      checkOutput("d_first_start", n, 16 * 104);
      run = 0;
      while (gpio_d[p] === 1'b0 && run < 300) begin
        @(negedge clk);
        run++;
      end
      checkOutput("d_bit_period", run, 104);
      repeat (52) @(negedge clk);
    end else begin
      repeat (156) @(negedge clk);
    end
    for (int j = 0; j < 8; j++) begin
      ch[j] = gpio_d[p];
      if (j < 7) repeat (104) @(negedge clk);
    end
    repeat (104) @(negedge clk);
    checkOutput("d_stop_bit", gpio_d[p], 1'b1);
  endtask

  initial begin
    int n;
    int quiet_bad;
    logic [7:0] ch;
    applyStimulus(1'b1, 1'b1);
    reset_d  = 1'b1;
    enable_d = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_gpio", gpio_s, 32'hFFFF_FFFF);
    checkOutput("reset_busy", busy_s, 1'b0);
    checkOutput("reset_msg_done", msg_done_s, 1'b0);

    applyStimulus(1'b0, 1'b1);
    wait_start(0, n);
    checkOutput("first_start", n, 16);
    frame_check(0, "2", "3");

    wait_start(24, n);
    checkOutput("gap_before_p24", n, 16);
    frame_check(24, "4", "4");

    wait_start(23, n);
    checkOutput("gap_before_p23", n, 16);
    frame_check(23, "0", "6");

    // Drop enable in data bit 3 of char 2, then confirm a clean stop and a quiet line.
    wait_start(0, n);
    checkOutput("gap_before_drop", n, 16);
    run_bad = 0; run_shared = 0; run_diff = 0; run_done = 0;
    sample_run(0, "2", "3", 0, 196);
    applyStimulus(1'b0, 1'b0);
    sample_run(0, "2", "3", 196, 240);
    checkOutput("drop_char2_complete", run_bad, 0);
    checkOutput("drop_busy_low", busy_s, 1'b0);
    quiet_bad = 0;
    for (int i = 0; i < 400; i++) begin
      if (gpio_s !== '1 || msg_done_s !== 1'b0 || busy_s !== 1'b0) quiet_bad++;
      @(negedge clk);
    end
    checkOutput("drop_no_msg_done", run_done, 0);
    checkOutput("drop_quiet_line", quiet_bad, 0);
    applyStimulus(1'b0, 1'b1);
    wait_start(0, n);
    checkOutput("reenable_gap", n, 16);
    frame_check(0, "2", "3");

    wait_start(0, n);
    checkOutput("gap_before_reset", n, 16);
    sample_run(0, "2", "3", 0, 36);
    checkOutput("pre_reset_low", gpio_s[0], 1'b0);
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("async_reset_gpio", gpio_s, 32'hFFFF_FFFF);
    checkOutput("async_reset_busy", busy_s, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1);
    wait_start(0, n);
    checkOutput("restart_full_gap", n, 16);

    @(negedge clk);
    reset_d = 1'b0;
    for (int c = 0; c < 8; c++) begin
      decode_d(31, (c == 0), ch);
      checkOutput($sformatf("d_pin2_char%0d", c), ch, exp_char(c, "0", "2"));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
